// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multicycle RV32I control path: ALU operations,
// opcodes, datapath mux selects and the control FSM state set.
package riscv_pkg;

    typedef enum logic [3:0] {
        CTRL_ADD  = 4'b0000,
        CTRL_SUB  = 4'b0001,
        CTRL_AND  = 4'b0010,
        CTRL_OR   = 4'b0011,
        CTRL_XOR  = 4'b0100,
        CTRL_SLL  = 4'b0101,
        CTRL_SRL  = 4'b0110,
        CTRL_SRA  = 4'b0111,
        CTRL_SLT  = 4'b1000,
        CTRL_SLTU = 4'b1001
    } control_operation;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_ERROR    = 4'd15
    } state_t;

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// Maps R/I-type instruction fields to the ALU operation; op5 separates
// R-type (funct7b5 selects SUB) from I-type (funct7b5 is immediate data).
module alu_decoder
    import riscv_pkg::*;
(
    input  logic             op5,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    output control_operation alu_op
);

    always_comb begin
        alu_op = CTRL_ADD;
        case (funct3)
            3'b000: alu_op = (op5 && funct7b5) ? CTRL_SUB : CTRL_ADD;
            3'b001: alu_op = CTRL_SLL;
            3'b010: alu_op = CTRL_SLT;
            3'b011: alu_op = CTRL_SLTU;
            3'b100: alu_op = CTRL_XOR;
            3'b101: alu_op = funct7b5 ? CTRL_SRA : CTRL_SRL;
            3'b110: alu_op = CTRL_OR;
            3'b111: alu_op = CTRL_AND;
            default: alu_op = CTRL_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multicycle RV32I core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives every datapath control.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 when memory is ready
// DECODE   | compute branch/jump target from OldPC + imm, pick path
// MEMADR   | rs1 + imm address for load/store
// MEMREAD  | load access, wait for MemReady
// MEMWB    | write loaded data to rd
// MEMWRITE | store access, MemWrite held until MemReady
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | write ALUOut to rd
// BRANCH   | compare rs1/rs2, load target into PC if taken
// JAL      | PC <- target, ALU computes link address
// JALR     | rs1 + imm target
// JALR2    | PC <- target, ALU computes link address
// LUI      | 0 + U-imm
// AUIPC    | OldPC + U-imm
// ERROR    | illegal instruction, halted until reset
module multicycle_control_fsm
    import riscv_pkg::*;
#(
    parameter int STATE_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic                   funct7b5,
    input  logic                   ZeroFlag,
    input  logic                   NegativeFlag,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   AdrSrc,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic [1:0]             ResultSrc,
    output logic [1:0]             ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [2:0]             ImmSrc,
    output logic                   RegWrite,
    output logic [3:0]             ALUControl,
    output logic                   Halt,
    output logic [STATE_WIDTH-1:0] State
);

    state_t           state;
    state_t           state_next;
    control_operation dec_op;
    control_operation alu_control;
    logic             pc_write;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;

    // Branch decisions use only ZeroFlag; the negative flag is reserved.
    logic unused_negative;
    assign unused_negative = NegativeFlag;

    alu_decoder u_alu_decoder (
        .op5      (op[5]),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_op   (dec_op)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        pc_write    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ImmSrc      = IMM_I;
        alu_control = CTRL_ADD;
        Halt        = 1'b0;

        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default:           state_next = S_ERROR;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
                state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_next = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA     = SRCA_RD1;
                alu_control = dec_op;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA     = SRCA_RD1;
                ALUSrcB     = SRCB_IMM;
                alu_control = dec_op;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                state_next = S_ALUWB;
            end
            S_JAL, S_JALR2: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = S_JALR2;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                state_next = S_FETCH;
                // SLT/SLTU leave a nonzero result when "less than" holds.
                case (funct3)
                    F3_BEQ:  begin alu_control = CTRL_SUB;  pc_write =  ZeroFlag; end
                    F3_BNE:  begin alu_control = CTRL_SUB;  pc_write = !ZeroFlag; end
                    F3_BLT:  begin alu_control = CTRL_SLT;  pc_write = !ZeroFlag; end
                    F3_BGE:  begin alu_control = CTRL_SLT;  pc_write =  ZeroFlag; end
                    F3_BLTU: begin alu_control = CTRL_SLTU; pc_write = !ZeroFlag; end
                    F3_BGEU: begin alu_control = CTRL_SLTU; pc_write =  ZeroFlag; end
                    default: state_next = S_ERROR;
                endcase
            end
            S_ERROR: begin
                Halt = 1'b1;
            end
            default: state_next = S_ERROR;
        endcase
    end

    assign PCWrite    = pc_write  & rst_n;
    assign IRWrite    = ir_write  & rst_n;
    assign MemWrite   = mem_write & rst_n;
    assign RegWrite   = reg_write & rst_n;
    assign ALUControl = alu_control;
    assign State      = STATE_WIDTH'(state);

endmodule
